// File: rtl/mii_fcs_check.sv
// MII receive FCS checker: strips the trailing 4-byte FCS through an 8-nibble delay line,
// runs a nibble-serial CRC-32 over the whole frame and reports length/runt/giant/odd status.
module mii_fcs_check #(
  parameter int MIN_BYTES = 64,
  parameter int MAX_BYTES = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  d,
  input  logic        dv,
  output logic [3:0]  q,
  output logic        qv,
  output logic        done,
  output logic        fcs_ok,
  output logic        runt,
  output logic        giant,
  output logic        odd,
  output logic [10:0] length
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_PRESET  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_LEN     = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_LEN     = 11'(MAX_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PASS = 2'd2
  } state_t;

  // Reflected CRC-32 advanced by one nibble, LSB of the nibble first.
  function automatic logic [31:0] crc32_nibble(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_t        state_r, state_s;
  logic [31:0]   dl_r;
  logic [11:0]   cnt_r, cnt_next_s;
  logic [31:0]   crc_r, crc_next_s;
  logic [3:0]    q_r;
  logic          qv_r, done_r, fcs_ok_r, runt_r, giant_r, odd_r;
  logic [10:0]   length_r;
  logic [10:0]   len_s;
  logic          runt_s, giant_s, odd_s, good_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: a frame is a run of dv=1; the 8th nibble fills the delay line.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (dv) state_s = FILL;
        else    state_s = IDLE;
      end
      FILL: begin
        if (!dv)                 state_s = IDLE;
        else if (cnt_r == 12'd7) state_s = PASS;
        else                     state_s = FILL;
      end
      PASS: begin
        if (!dv) state_s = IDLE;
        else     state_s = PASS;
      end
      default: state_s = IDLE;
    endcase
  end

  // Counter/CRC next values; a nibble seen in IDLE starts a fresh frame.
  always_comb begin
    cnt_next_s = cnt_r;
    crc_next_s = crc_r;
    if (state_r == IDLE) begin
      cnt_next_s = 12'd1;
      crc_next_s = crc32_nibble(CRC_PRESET, d);
    end else begin
      if (cnt_r == 12'hFFF) cnt_next_s = cnt_r;
      else                  cnt_next_s = cnt_r + 12'd1;
      crc_next_s = crc32_nibble(crc_r, d);
    end
  end

  // End-of-frame status derived from the completed count and CRC register.
  always_comb begin
    len_s   = cnt_r[11:1];
    runt_s  = (len_s < MIN_LEN);
    giant_s = (len_s > MAX_LEN);
    odd_s   = cnt_r[0];
    good_s  = (crc_r == CRC_RESIDUE);
  end

  // Datapath: delay line, payload output and end-of-frame status capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_r     <= 32'd0;
      cnt_r    <= 12'd0;
      crc_r    <= 32'd0;
      q_r      <= 4'd0;
      qv_r     <= 1'b0;
      done_r   <= 1'b0;
      fcs_ok_r <= 1'b0;
      runt_r   <= 1'b0;
      giant_r  <= 1'b0;
      odd_r    <= 1'b0;
      length_r <= 11'd0;
    end else begin
      if (dv) begin
        dl_r  <= {dl_r[27:0], d};
        cnt_r <= cnt_next_s;
        crc_r <= crc_next_s;
      end
      // Only nibbles that are at least 8 behind the input ever leave, so the FCS never does.
      if (dv && (state_r == PASS)) begin
        q_r  <= dl_r[31:28];
        qv_r <= 1'b1;
      end else begin
        q_r  <= 4'd0;
        qv_r <= 1'b0;
      end
      if (!dv && (state_r != IDLE)) begin
        done_r   <= 1'b1;
        fcs_ok_r <= good_s & ~runt_s & ~giant_s & ~odd_s;
        runt_r   <= runt_s;
        giant_r  <= giant_s;
        odd_r    <= odd_s;
        length_r <= len_s;
      end else begin
        done_r   <= 1'b0;
      end
    end
  end

  assign q      = q_r;
  assign qv     = qv_r;
  assign done   = done_r;
  assign fcs_ok = fcs_ok_r;
  assign runt   = runt_r;
  assign giant  = giant_r;
  assign odd    = odd_r;
  assign length = length_r;

endmodule

// File: tb/tb_mii_fcs_check.sv
// Self-checking bench for mii_fcs_check: frame-level model builds per-cycle expectations
// (payload nibbles, done strobe, status) that one compare process checks every cycle.
module tb_mii_fcs_check;

  typedef struct packed {
    logic        fcs_ok;
    logic        runt;
    logic        giant;
    logic        odd;
    logic [10:0] length;
  } stat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  d = 4'd0;
  logic        dv = 1'b0;
  logic [3:0]  q;
  logic        qv, done, fcs_ok, runt, giant, odd;
  logic [10:0] length;

  mii_fcs_check dut (
    .clk(clk), .reset(reset), .d(d), .dv(dv), .q(q), .qv(qv), .done(done),
    .fcs_ok(fcs_ok), .runt(runt), .giant(giant), .odd(odd), .length(length)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          qv_cnt = 0;
  int          done_cnt = 0;
  bit          chk_en = 1'b0;
  stat_t       exp_stat = '0;
  logic [3:0]  exp_q [int];
  stat_t       exp_done [int];
  logic [7:0]  pl [$];
  logic [3:0]  fr_nib [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Expected status from frame-level rules: sizes from the nibble count, CRC by comparing the
  // trailing 4 bytes with the CRC of everything before them.
  function automatic stat_t model_stat();
    stat_t s;
    int n, c, nb;
    logic [31:0] crc, fcs;
    logic good;
    n = fr_nib.size();
    c = (n > 4095) ? 4095 : n;
    s.length = 11'(c / 2);
    s.runt   = ((c / 2) < 64);
    s.giant  = ((c / 2) > 1518);
    s.odd    = (c % 2) == 1;
    good = 1'b0;
    if ((n % 2 == 0) && (n >= 8)) begin
      nb = n / 2;
      crc = 32'hFFFFFFFF;
      for (int k = 0; k < nb - 4; k++) crc = crc_byte(crc, {fr_nib[2*k+1], fr_nib[2*k]});
      fcs = 32'd0;
      for (int j = 0; j < 4; j++) fcs[8*j +: 8] = {fr_nib[2*(nb-4+j)+1], fr_nib[2*(nb-4+j)]};
      good = (fcs == ~crc);
    end
    s.fcs_ok = good && !s.runt && !s.giant && !s.odd;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, expv);
    end
  endtask

  // Payload in pl -> nibble stream with correct FCS appended, low nibble first.
  task automatic make_from_pl();
    logic [31:0] crc;
    logic [7:0]  b;
    fr_nib.delete();
    crc = 32'hFFFFFFFF;
    foreach (pl[i]) begin
      crc = crc_byte(crc, pl[i]);
      fr_nib.push_back(pl[i][3:0]);
      fr_nib.push_back(pl[i][7:4]);
    end
    crc = ~crc;
    for (int j = 0; j < 4; j++) begin
      b = crc[8*j +: 8];
      fr_nib.push_back(b[3:0]);
      fr_nib.push_back(b[7:4]);
    end
  endtask

  task automatic load_known();
    logic [7:0] mid [10];
    mid = '{8'hD0, 8'h50, 8'h99, 8'h7C, 8'hE4, 8'h32, 8'h55, 8'h55, 8'h01, 8'h00};
    pl.delete();
    repeat (6) pl.push_back(8'hFF);
    for (int i = 0; i < 10; i++) pl.push_back(mid[i]);
    repeat (44) pl.push_back(8'h00);
    make_from_pl();
  endtask

  task automatic load_random(input int nbytes);
    pl.delete();
    repeat (nbytes) pl.push_back(8'($urandom_range(0, 255)));
    make_from_pl();
  endtask

  // Drives fr_nib as one frame starting now, then gap idle cycles (gap >= 1).
  task automatic drive_frame(input int gap);
    int n, t0;
    n = fr_nib.size();
    t0 = cyc;
    for (int k = 0; k + 8 < n; k++) exp_q[t0 + k + 9] = fr_nib[k];
    exp_done[t0 + n + 1] = model_stat();
    for (int k = 0; k < n; k++) begin
      d = fr_nib[k];
      dv = 1'b1;
      @(posedge clk); #1;
    end
    dv = 1'b0;
    d = 4'd0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Per-cycle comparison of every output against the model's expectations.
  always @(negedge clk) begin : cmp
    logic [3:0] eq;
    logic       eqv, ed;
    if (chk_en) begin
      eqv = exp_q.exists(cyc);
      eq  = eqv ? exp_q[cyc] : 4'd0;
      ed  = exp_done.exists(cyc);
      if (ed) exp_stat = exp_done[cyc];
      tests++;
      if (qv !== eqv || q !== eq || done !== ed ||
          {fcs_ok, runt, giant, odd, length} !== exp_stat) begin
        fails++;
        $display("FAIL cycle_cmp cyc=%0d got qv=%b q=%h done=%b stat=%h, want qv=%b q=%h done=%b stat=%h",
                 cyc, qv, q, done, {fcs_ok, runt, giant, odd, length}, eqv, eq, ed, exp_stat);
      end
      if (qv)   qv_cnt++;
      if (done) done_cnt++;
    end
  end

  initial begin
    int q0, d0, t0, r, gap;
    logic [7:0] s9 [9];

    // Pin the model CRC with the standard check value.
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    begin
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) c = crc_byte(c, s9[i]);
      chk("crc_check_value", ~c, 32'hCBF43926);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {q, qv, done, fcs_ok, runt, giant, odd, length}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Known 60-byte frame plus FCS.
    load_known();
    chk("known_nibbles", fr_nib.size(), 32'd128);
    q0 = qv_cnt;
    drive_frame(1);
    chk("known_qv_cycles", qv_cnt - q0, 32'd120);
    chk("known_done", done, 32'd1);
    chk("known_status", {fcs_ok, runt, giant, odd, length}, {4'b1000, 11'd64});

    // Corrupted nibble 20.
    load_known();
    fr_nib[20] = fr_nib[20] ^ 4'h1;
    drive_frame(1);
    chk("corrupt_status", {fcs_ok, runt, giant, odd, length}, {4'b0000, 11'd64});

    // 3-nibble burst.
    fr_nib.delete();
    fr_nib.push_back(4'h1); fr_nib.push_back(4'h2); fr_nib.push_back(4'h3);
    q0 = qv_cnt;
    drive_frame(1);
    chk("burst_qv_cycles", qv_cnt - q0, 32'd0);
    chk("burst_status", {done, fcs_ok, runt, giant, odd, length}, {5'b10101, 11'd1});

    // Back-to-back 64-byte and 1519-byte frames with one idle cycle.
    load_known();
    drive_frame(1);
    chk("b2b_first", {done, fcs_ok, giant, length}, {3'b110, 11'd64});
    load_random(1515);
    drive_frame(1);
    chk("b2b_giant", {done, fcs_ok, giant, length}, {3'b101, 11'd1519});
    repeat (2) begin @(posedge clk); #1; end

    // Reset after 50 nibbles, then a good frame.
    load_known();
    t0 = cyc;
    for (int n = 0; n + 9 < 50; n++) exp_q[t0 + n + 9] = fr_nib[n];
    d0 = done_cnt;
    for (int k = 0; k < 50; k++) begin
      d = fr_nib[k]; dv = 1'b1;
      @(posedge clk); #1;
    end
    dv = 1'b0; d = 4'd0;
    reset = 1'b1;
    exp_stat = '0;
    #1;
    chk("midreset_outputs", {q, qv, done, fcs_ok, runt, giant, odd, length}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    load_known();
    drive_frame(1);
    chk("after_reset_status", {done, fcs_ok, length}, {2'b11, 11'd64});
    @(negedge clk); #1;
    chk("after_reset_done_count", done_cnt - d0, 32'd1);
    @(posedge clk); #1;

    // Extra trailing nibble.
    load_known();
    fr_nib.push_back(4'hA);
    drive_frame(1);
    chk("odd_status", {fcs_ok, runt, giant, odd, length}, {4'b0001, 11'd64});

    // Randomized frames: good, corrupted, odd-length, runts and short bursts.
    for (int f = 0; f < 16; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        fr_nib.delete();
        repeat ($urandom_range(1, 7)) fr_nib.push_back(4'($urandom_range(0, 15)));
      end else begin
        load_random($urandom_range(40, 120));
        if (r <= 3) begin
          int idx;
          idx = $urandom_range(0, fr_nib.size() - 1);
          fr_nib[idx] = fr_nib[idx] ^ 4'($urandom_range(1, 15));
        end else if (r == 4) begin
          fr_nib.push_back(4'($urandom_range(0, 15)));
        end else begin
          fr_nib = fr_nib;
        end
      end
      gap = $urandom_range(1, 3);
      drive_frame(gap);
    end

    repeat (4) begin @(posedge clk); #1; end
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mii_fcs_check.md
MII_FCS_CHECK -- requirements
Module: mii_fcs_check

Interface
REQ-001 Parameter MIN_BYTES, default 64, minimum legal frame length in bytes, FCS included.
REQ-002 Parameter MAX_BYTES, default 1518, maximum legal frame length in bytes, FCS included.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port d  input  4  receive nibble from the deframer, preamble/SFD already removed, low nibble of each byte first.
REQ-006 Port dv  input  1  d valid; a contiguous run of dv=1 cycles is one frame.
REQ-007 Port q  output  4  payload nibble with the 4-byte FCS stripped.
REQ-008 Port qv  output  1  q valid.
REQ-009 Port done  output  1  one-cycle end-of-frame strobe.
REQ-010 Port fcs_ok  output  1  frame passed all checks; valid while done=1, held until next done.
REQ-011 Port runt  output  1  frame shorter than MIN_BYTES; valid and held as fcs_ok.
REQ-012 Port giant  output  1  frame longer than MAX_BYTES; valid and held as fcs_ok.
REQ-013 Port odd  output  1  frame had an odd nibble count; valid and held as fcs_ok.
REQ-014 Port length  output  11  frame length in whole bytes, FCS included; valid and held as fcs_ok.

Function
REQ-015 The block SHALL have states IDLE, FILL, PASS; IDLE->FILL on dv=1; FILL->PASS after 8 nibbles sampled; FILL or PASS->IDLE on the first sampled dv=0.
REQ-016 The block SHALL hold each nibble in an 8-entry delay line, presenting nibble n on q, with qv=1, in the cycle after nibble n+8 is sampled.
REQ-017 The last 8 nibbles of every frame (the FCS) SHALL never appear on q.
REQ-018 qv SHALL be 0 in IDLE and FILL and in the cycle after dv=0 is sampled; q SHALL be 0 whenever qv=0.
REQ-019 The block SHALL compute CRC-32 nibble-serially over every sampled nibble, FCS included, using reflected polynomial 0xEDB88320 and register preset to 0xFFFFFFFF at frame start.
REQ-020 A frame SHALL count as CRC-good when the final register equals residue 0xDEBB20E3.
REQ-021 The nibble counter SHALL be 12 bits and saturate at 0xFFF; length SHALL equal count>>1, saturating at 2047.
REQ-022 done SHALL pulse for exactly one cycle, registered on the edge that samples the first dv=0 after a frame.
REQ-023 runt = length<MIN_BYTES; giant = length>MAX_BYTES; odd = count bit 0.
REQ-024 fcs_ok = CRC-good AND NOT runt AND NOT giant AND NOT odd.
REQ-025 A frame of fewer than 8 nibbles SHALL produce no qv cycles, done=1, runt=1, fcs_ok=0.
REQ-026 One idle cycle between frames SHALL be sufficient; if dv=1 in the cycle done=1, that nibble SHALL start a new frame with CRC and count freshly preset.
REQ-027 Status outputs SHALL change only at done and SHALL NOT change mid-frame.

Reset
REQ-028 Reset SHALL force state IDLE and clear the delay line and counter; q, qv, done, fcs_ok, runt, giant, odd and length SHALL all be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first dv=1 after release SHALL start a new frame.

Verification
REQ-030 60-byte frame (FF x6, D0 50 99 7C E4 32, 55 55 01 00, 44 x 00) plus correct FCS, 128 nibbles -> qv for 120 cycles starting 9 cycles after first dv; q reproduces the 60 bytes; done once; fcs_ok=1, length=64, runt=giant=odd=0.
REQ-031 Same frame, nibble 20 XORed with 0x1 -> q carries the corrupted nibble; done with fcs_ok=0 and runt=giant=odd=0.
REQ-032 3-nibble burst -> no qv cycles; done, runt=1, fcs_ok=0, length=1, odd=1.
REQ-033 Valid 64-byte frame, 1 idle cycle, then valid 1519-byte frame -> two done pulses: first fcs_ok=1, length=64; second giant=1, fcs_ok=0, length=1519.
REQ-034 Reset pulsed after 50 nibbles of a frame, then valid 64-byte frame -> no done for the aborted frame; one done with fcs_ok=1, length=64.
REQ-035 Valid frame with one extra trailing nibble (129 nibbles) -> odd=1, fcs_ok=0, length=64.
